// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: arbiter state encoding and default bus dimensions.
package bus_arbiter_pkg;

    localparam int unsigned DEF_NUM_MASTERS = 3;
    localparam int unsigned DEF_TIMEOUT_LEN = 6;
    localparam int unsigned DEF_ID_WIDTH    = 2;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE     = 2'b00;
    localparam logic [STATE_W-1:0] ST_GRANTED  = 2'b01;
    localparam logic [STATE_W-1:0] ST_HANDOVER = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = ST_IDLE,
        GRANTED  = ST_GRANTED,
        HANDOVER = ST_HANDOVER
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbitration handshake between requesting masters and the bus arbiter.
interface bus_arbiter_if
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int unsigned ID_WIDTH    = DEF_ID_WIDTH
);

    logic [NUM_MASTERS-1:0] b_request;
    logic                   b_bus_utilizing;
    logic [NUM_MASTERS-1:0] b_grant;
    logic [ID_WIDTH-1:0]    owner_id;
    logic                   bus_granted;
    logic                   slv_bsy_drive;
    logic                   timeout_err;

    // Requester side
    modport master (
        output b_request, b_bus_utilizing,
        input  b_grant, owner_id, bus_granted, slv_bsy_drive, timeout_err
    );

    // Arbiter side
    modport slave (
        input  b_request, b_bus_utilizing,
        output b_grant, owner_id, bus_granted, slv_bsy_drive, timeout_err
    );

endinterface

// File: rtl/bus_arbiter_rr_select.sv
// Combinational round-robin picker: first requester above last_owner, wrapping.
module rr_select
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int unsigned ID_WIDTH    = DEF_ID_WIDTH
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [ID_WIDTH-1:0]    last_owner,
    output logic [ID_WIDTH-1:0]    winner,
    output logic                   any_req
);

    localparam int unsigned SEL_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    int unsigned idx;
    logic        found;

    always_comb begin
        winner  = '0;
        found   = 1'b0;
        idx     = 0;
        any_req = |req;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            idx = (32'(last_owner) + i) % NUM_MASTERS;
            if (!found && req[SEL_W'(idx)]) begin
                found  = 1'b1;
                winner = ID_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with one-cycle handover gap and idle-timeout revocation.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int unsigned TIMEOUT_LEN = DEF_TIMEOUT_LEN,
    parameter int unsigned ID_WIDTH    = DEF_ID_WIDTH
) (
    input logic         clk,
    input logic         rstn,
    bus_arbiter_if.slave bus
);

    localparam logic [ID_WIDTH-1:0] LAST_OWNER_RST = ID_WIDTH'(NUM_MASTERS - 1);

    arb_state_e             state;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [ID_WIDTH-1:0]    owner_q;
    logic [ID_WIDTH-1:0]    last_owner;
    logic                   granted_q;
    logic                   slv_bsy_q;
    logic                   timeout_q;
    logic [TIMEOUT_LEN-1:0] idle_cnt;

    logic [ID_WIDTH-1:0]    winner;
    logic                   any_req;
    logic                   owner_req;
    logic                   other_req;
    logic                   at_limit;

    rr_select #(
        .NUM_MASTERS (NUM_MASTERS),
        .ID_WIDTH    (ID_WIDTH)
    ) u_rr_select (
        .req        (bus.b_request),
        .last_owner (last_owner),
        .winner     (winner),
        .any_req    (any_req)
    );

    // Grant is one-hot, so masking with it isolates the owner's request
    assign owner_req = |(bus.b_request & grant_q);
    assign other_req = |(bus.b_request & ~grant_q);
    assign at_limit  = &idle_cnt;

    always_ff @(posedge clk) begin : arb_fsm
        if (!rstn) begin
            state      <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            granted_q  <= 1'b0;
            slv_bsy_q  <= 1'b1;
            timeout_q  <= 1'b0;
            idle_cnt   <= '0;
            last_owner <= LAST_OWNER_RST;
        end else begin
            timeout_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_q   <= NUM_MASTERS'(1) << winner;
                        owner_q   <= winner;
                        granted_q <= 1'b1;
                        slv_bsy_q <= 1'b0;
                        idle_cnt  <= '0;
                        state     <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (!owner_req || (at_limit && other_req && !bus.b_bus_utilizing)) begin
                        grant_q    <= '0;
                        granted_q  <= 1'b0;
                        slv_bsy_q  <= 1'b1;
                        last_owner <= owner_q;
                        state      <= HANDOVER;
                        // A voluntary release wins over a coincident timeout
                        timeout_q  <= owner_req;
                    end else if (bus.b_bus_utilizing) begin
                        idle_cnt <= '0;
                    end else if (!at_limit) begin
                        idle_cnt <= idle_cnt + TIMEOUT_LEN'(1);
                    end
                end
                HANDOVER: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    assign bus.b_grant       = grant_q;
    assign bus.owner_id      = owner_q;
    assign bus.bus_granted   = granted_q;
    assign bus.slv_bsy_drive = slv_bsy_q;
    assign bus.timeout_err   = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, single grant, round-robin, timeout, no-preemption, reset mid-transfer.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_pass;
    int   bad;
    int   order [4];

    bus_arbiter_if #(.NUM_MASTERS(3), .ID_WIDTH(2)) bus ();

    bus_arbiter #(
        .NUM_MASTERS (3),
        .TIMEOUT_LEN (6),
        .ID_WIDTH    (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;
        rstn = 1'b0;
        bus.b_request = 3'b111;
        bus.b_bus_utilizing = 1'b0;

        // Reset held two cycles with all masters requesting
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_grant", 8'(bus.b_grant), 8'h00);
            check("rst_slv_bsy", 8'(bus.slv_bsy_drive), 8'h01);
        end
        check("rst_granted", 8'(bus.bus_granted), 8'h00);
        check("rst_owner", 8'(bus.owner_id), 8'h00);
        check("rst_timeout", 8'(bus.timeout_err), 8'h00);
        check("rst_state", 8'(dut.state), 8'(IDLE));

        rstn = 1'b1;
        bus.b_request = 3'b000;
        tick();
        check("idle_nogrant", 8'(bus.b_grant), 8'h00);

        // Single master 1: grant one cycle after request, release takes one HANDOVER cycle
        bus.b_request = 3'b010;
        bus.b_bus_utilizing = 1'b1;
        tick();
        check("single_grant", 8'(bus.b_grant), 8'h02);
        check("single_owner", 8'(bus.owner_id), 8'h01);
        check("single_granted", 8'(bus.bus_granted), 8'h01);
        check("single_slv_bsy", 8'(bus.slv_bsy_drive), 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("single_hold", 8'(bus.b_grant), 8'h02);
        end
        bus.b_request = 3'b000;
        bus.b_bus_utilizing = 1'b0;
        tick();
        check("single_release", 8'(bus.b_grant), 8'h00);
        check("single_rel_slv", 8'(bus.slv_bsy_drive), 8'h01);
        check("single_handover", 8'(dut.state), 8'(HANDOVER));
        tick();
        check("single_idle", 8'(dut.state), 8'(IDLE));

        // Round-robin from reset: order 0,1,2,0 with two empty cycles between grants
        do_reset();
        bus.b_request = 3'b111;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("rr_grant", 8'(bus.b_grant), 8'(3'b001 << order[k]));
            check("rr_owner", 8'(bus.owner_id), 8'(order[k]));
            for (int i = 0; i < 3; i++) begin
                tick();
                check("rr_hold", 8'(bus.b_grant), 8'(3'b001 << order[k]));
            end
            bus.b_request = 3'b111 & ~(3'b001 << order[k]);
            tick();
            check("rr_gap1", 8'(bus.b_grant), 8'h00);
            check("rr_handover", 8'(dut.state), 8'(HANDOVER));
            bus.b_request = (k == 3) ? 3'b000 : 3'b111;
            tick();
            check("rr_gap2", 8'(bus.b_grant), 8'h00);
            tick();
        end
        check("rr_end_idle", 8'(bus.b_grant), 8'h00);

        // Timeout: master 0 idles 63 cycles while master 2 waits
        do_reset();
        bus.b_request = 3'b001;
        bus.b_bus_utilizing = 1'b0;
        tick();
        check("to_grant0", 8'(bus.b_grant), 8'h01);
        bus.b_request = 3'b101;
        bad = 0;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (bus.b_grant !== 3'b001 || bus.timeout_err !== 1'b0) bad++;
        end
        check("to_hold", 8'(bad), 8'h00);
        check("to_cnt_limit", 8'(dut.idle_cnt), 8'd63);
        tick();
        check("to_err_pulse", 8'(bus.timeout_err), 8'h01);
        check("to_revoked", 8'(bus.b_grant), 8'h00);
        tick();
        check("to_err_clear", 8'(bus.timeout_err), 8'h00);
        check("to_gap", 8'(bus.b_grant), 8'h00);
        tick();
        check("to_grant2", 8'(bus.b_grant), 8'h04);
        check("to_owner2", 8'(bus.owner_id), 8'h02);

        // Counter saturates with no other requester: grant kept
        bus.b_request = 3'b100;
        bad = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (bus.b_grant !== 3'b100 || bus.timeout_err !== 1'b0) bad++;
        end
        check("sat_keep", 8'(bad), 8'h00);
        check("sat_cnt", 8'(dut.idle_cnt), 8'd63);

        // Release coinciding with timeout is a normal release
        bus.b_request = 3'b001;
        tick();
        check("coinc_release", 8'(bus.b_grant), 8'h00);
        check("coinc_no_err", 8'(bus.timeout_err), 8'h00);
        tick();
        tick();
        check("coinc_next", 8'(bus.b_grant), 8'h01);

        // No preemption: bus activity every 40 cycles keeps the counter below limit
        do_reset();
        bus.b_request = 3'b001;
        tick();
        check("np_grant0", 8'(bus.b_grant), 8'h01);
        bus.b_request = 3'b101;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            bus.b_bus_utilizing = ((i % 40) == 39);
            tick();
            if (bus.b_grant !== 3'b001 || bus.timeout_err !== 1'b0) bad++;
        end
        check("np_retained", 8'(bad), 8'h00);
        bus.b_bus_utilizing = 1'b0;

        // Reset mid-transfer drops the grant on that edge; master 0 wins afterwards
        do_reset();
        bus.b_request = 3'b010;
        bus.b_bus_utilizing = 1'b1;
        tick();
        check("mid_grant1", 8'(bus.b_grant), 8'h02);
        tick();
        rstn = 1'b0;
        tick();
        check("mid_rst_grant", 8'(bus.b_grant), 8'h00);
        check("mid_rst_slv", 8'(bus.slv_bsy_drive), 8'h01);
        check("mid_rst_granted", 8'(bus.bus_granted), 8'h00);
        rstn = 1'b1;
        bus.b_request = 3'b111;
        bus.b_bus_utilizing = 1'b0;
        tick();
        check("mid_first_m0", 8'(bus.b_grant), 8'h01);
        check("mid_owner0", 8'(bus.owner_id), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 3: number of requesting masters (2..8).
REQ-002 Parameter TIMEOUT_LEN, default 6: idle-timeout counter width in bits (limit = 2^TIMEOUT_LEN-1 cycles).
REQ-003 Parameter ID_WIDTH, default 2: width of owner index (>= clog2(NUM_MASTERS)).
REQ-004 Port clk  input  1  single clock; all logic rising-edge.
REQ-005 Port rstn  input  1  synchronous active-low reset.
REQ-006 Port b_request  input  NUM_MASTERS  per-master request; bit i from master i.
REQ-007 Port b_bus_utilizing  input  1  shared line, high while the granted master drives a transfer.
REQ-008 Port b_grant  output  NUM_MASTERS  one-hot-or-zero grant, registered.
REQ-009 Port owner_id  output  ID_WIDTH  index of current grant holder; valid when bus_granted=1.
REQ-010 Port bus_granted  output  1  high while any grant bit is high.
REQ-011 Port slv_bsy_drive  output  1  high when no master holds the bus; enables arbiter to hold slave_busy line high.
REQ-012 Port timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-013 States SHALL be IDLE, GRANTED, HANDOVER; encoding 2 bits.
REQ-014 IDLE: when any b_request bit high at an edge, SHALL set b_grant to the winner and enter GRANTED on that edge (grant visible 1 cycle after request sampled).
REQ-015 Winner SHALL be round-robin: first requesting index searching upward from last_owner+1, wrapping modulo NUM_MASTERS.
REQ-016 last_owner SHALL reset to NUM_MASTERS-1 so master 0 wins the first contention.
REQ-017 GRANTED: grant SHALL be held while b_request[owner_id] stays high; no preemption while b_bus_utilizing=1.
REQ-018 GRANTED: owner drops b_request -> b_grant cleared next edge, last_owner<=owner_id, state HANDOVER.
REQ-019 HANDOVER SHALL last exactly one cycle with b_grant=0, then IDLE; minimum gap between grants = 2 cycles.
REQ-020 Idle counter SHALL increment each GRANTED cycle with b_bus_utilizing=0, clear on any cycle with b_bus_utilizing=1 and on entry to GRANTED; saturates at limit.
REQ-021 Counter at limit AND any other request bit high AND b_bus_utilizing=0: grant revoked next edge, timeout_err pulses 1 cycle, state HANDOVER, last_owner<=owner_id.
REQ-022 Counter at limit with no other requester: grant SHALL be kept, no timeout_err.
REQ-023 Owner dropping request and timeout in same cycle: treated as normal release, no timeout_err.
REQ-024 Request bits changing in HANDOVER SHALL be ignored until IDLE.
REQ-025 b_grant SHALL never have more than one bit high; bus_granted = |b_grant; slv_bsy_drive = ~bus_granted.
REQ-026 Requests on bits >= NUM_MASTERS impossible by width; owner_id upper unused values never produced.

Reset
REQ-027 rstn low at an edge: state IDLE, b_grant=0, owner_id=0, bus_granted=0, slv_bsy_drive=1, timeout_err=0, counter=0, last_owner=NUM_MASTERS-1.
REQ-028 Reset mid-GRANTED SHALL drop grant on that same edge, regardless of b_bus_utilizing.

Structure
REQ-029 State encoding localparams and default NUM_MASTERS/TIMEOUT_LEN SHALL live in the shared bus package used by master and slave.
REQ-030 Round-robin priority selector SHALL be one combinational sub-module, rr_select (inputs request vector, last_owner; outputs winner index, any_req).

Verification
REQ-031 Reset: rstn low 2 cycles with b_request=3'b111 -> b_grant=0, slv_bsy_drive=1 throughout.
REQ-032 Single master: b_request=3'b010 at cycle 0 -> b_grant=3'b010 cycle 1, owner_id=1; drop request cycle 5 -> b_grant=0 cycle 6, HANDOVER cycle 6, IDLE cycle 7.
REQ-033 Round-robin: b_request=3'b111 held, each owner releases after 4 cycles -> grant order 0,1,2,0 with 2-cycle gaps.
REQ-034 Timeout: master 0 granted, b_bus_utilizing=0 for 63 cycles, b_request[2]=1 -> timeout_err pulse, grant 0 dropped, master 2 granted 2 cycles later.
REQ-035 No preemption: same as REQ-034 but b_bus_utilizing pulses every 40 cycles -> no timeout_err, grant retained.
REQ-036 Reset mid-transfer: rstn low while granted and b_bus_utilizing=1 -> b_grant=0 on that edge; after release master 0 wins first.
